// File: rtl/logic_op_arbiter.sv
// -----------------------------------------------------------------------------
// logic_op_arbiter
//
// Round-robin arbiter and sequencer in front of one shared bitwise logic
// unit. Up to N_REQ client engines present {opcode, a, b}. One of them is
// granted per cycle. The gate result is registered and tagged with the
// owner's index, and it is held until the consumer takes it.
//
// Opcodes: 0 AND, 1 OR, 2 NOT (~a), 3 NAND, 4 NOR, 5 XOR, 6 XNOR.
// Opcode 7 depends on the build:
//   - LOGIC_ARB_ERR_EN defined   : result 0, rsp_err=1 (illegal opcode).
//   - LOGIC_ARB_ERR_EN undefined : BUF, result = a. There is no rsp_err port.
//
// Handshake semantics (every channel): a transfer happens on a rising edge
// where valid and ready are both 1. A producer holds its payload stable while
// valid=1 and no transfer has happened yet. Request valid may be dropped
// before acceptance (the request is withdrawn). ready never depends on the
// payload. req_ready depends on req_valid, state and rsp_ready only.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   req_valid  in   [N_REQ]        per-requester valid
//   req_ready  out  [N_REQ]        per-requester accept (one-hot or zero)
//   req_op     in   [3*N_REQ]      opcode, requester i at [3i+2:3i]
//   req_a      in   [WIDTH*N_REQ]  operand A, requester i at slice i
//   req_b      in   [WIDTH*N_REQ]  operand B, requester i at slice i
//   rsp_valid  out  result valid
//   rsp_ready  in   consumer accepts result
//   rsp_data   out  [WIDTH] result
//   rsp_id     out  [ID_W]  owner of rsp_data
//   rsp_err    out  illegal opcode flag (LOGIC_ARB_ERR_EN only)
//   dbg_state  out  FSM state (0 IDLE, 1 RESP)
// -----------------------------------------------------------------------------
module logic_op_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8,
   parameter int ID_W  = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [3*N_REQ-1:0]     req_op,
   input  logic [WIDTH*N_REQ-1:0] req_a,
   input  logic [WIDTH*N_REQ-1:0] req_b,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [WIDTH-1:0]       rsp_data,
   output logic [ID_W-1:0]        rsp_id,
`ifdef LOGIC_ARB_ERR_EN
   output logic                   rsp_err,
`endif
   output logic                   dbg_state
);

   localparam logic S_IDLE = 1'b0;
   localparam logic S_RESP = 1'b1;

   logic            state;
   logic [ID_W-1:0] rr_ptr;

   logic            found;
   logic [ID_W-1:0] winner;
   logic [ID_W:0]   sum;
   logic [ID_W-1:0] cand;
   logic            can_accept;
   logic            accept;

   logic [2:0]       win_op;
   logic [WIDTH-1:0] win_a;
   logic [WIDTH-1:0] win_b;
   logic [WIDTH-1:0] op_res;
`ifdef LOGIC_ARB_ERR_EN
   logic             op_err;
`endif

   assign dbg_state  = state;
   assign rsp_valid  = (state == S_RESP);
   // A held result that retires this edge frees the output register for a
   // new one on the same edge, which gives one op per cycle.
   assign can_accept = (state == S_IDLE) | ((state == S_RESP) & rsp_ready);

   // Winner search starts at rr_ptr and wraps modulo N_REQ. sum is one bit
   // wider so that non-power-of-two N_REQ wraps correctly.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      sum    = '0;
      cand   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (sum >= (ID_W+1)'(N_REQ)) begin
            sum = sum - (ID_W+1)'(N_REQ);
         end
         cand = sum[ID_W-1:0];
         if (!found && req_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   // Ready is also gated by rst_n so that no requester sees a grant while
   // reset is asserted.
   always_comb begin
      req_ready = '0;
      for (int i = 0; i < N_REQ; i++) begin
         req_ready[i] = rst_n & can_accept & found & (winner == ID_W'(i));
      end
   end

   assign accept = found & can_accept;

   assign win_op = req_op[int'(winner)*3 +: 3];
   assign win_a  = req_a[int'(winner)*WIDTH +: WIDTH];
   assign win_b  = req_b[int'(winner)*WIDTH +: WIDTH];

   always_comb begin
      op_res = '0;
`ifdef LOGIC_ARB_ERR_EN
      op_err = 1'b0;
`endif
      case (win_op)
         3'd0: op_res = win_a & win_b;
         3'd1: op_res = win_a | win_b;
         3'd2: op_res = ~win_a;
         3'd3: op_res = ~(win_a & win_b);
         3'd4: op_res = ~(win_a | win_b);
         3'd5: op_res = win_a ^ win_b;
         3'd6: op_res = ~(win_a ^ win_b);
         default: begin
`ifdef LOGIC_ARB_ERR_EN
            op_res = '0;
            op_err = 1'b1;
`else
            op_res = win_a;
`endif
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         rr_ptr   <= '0;
         rsp_data <= '0;
         rsp_id   <= '0;
`ifdef LOGIC_ARB_ERR_EN
         rsp_err  <= 1'b0;
`endif
      end else if (accept) begin
         state    <= S_RESP;
         rsp_data <= op_res;
         rsp_id   <= winner;
`ifdef LOGIC_ARB_ERR_EN
         rsp_err  <= op_err;
`endif
         if (winner == ID_W'(N_REQ-1)) begin
            rr_ptr <= '0;
         end else begin
            rr_ptr <= winner + 1'b1;
         end
      end else if ((state == S_RESP) && rsp_ready) begin
         // Retire with nothing pending. The payload registers keep their
         // last value.
         state <= S_IDLE;
      end
   end

endmodule

// File: tb/tb_logic_op_arbiter.sv
// -----------------------------------------------------------------------------
// tb_logic_op_arbiter
//
// Directed bench for logic_op_arbiter (N_REQ=4, WIDTH=8). A behavioural
// model (pointer + held result) predicts req_ready and the response
// registers every cycle. Hand-computed literals pin the key scenarios, and a
// scoreboard queue holds the expected opcode-sweep results.
// -----------------------------------------------------------------------------
module tb_logic_op_arbiter;

   localparam int N = 4;
   localparam int W = 8;
   localparam int I = 2;

   // clock / reset
   logic clk;
   logic rst_n;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [3*N-1:0] req_op;
   logic [W*N-1:0] req_a;
   logic [W*N-1:0] req_b;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [W-1:0]   rsp_data;
   logic [I-1:0]   rsp_id;
   logic           dbg_state;
`ifdef LOGIC_ARB_ERR_EN
   logic           rsp_err;
`endif

   logic_op_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(I)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
`ifdef LOGIC_ARB_ERR_EN
      .rsp_err   (rsp_err),
`endif
      .dbg_state (dbg_state)
   );

   // scoreboard / counters
   int n_checks = 0;
   int n_errors = 0;
   logic [W-1:0] exp_q[$];
   logic         sb_on = 1'b0;

   // model state
   logic         m_valid;
   logic [W-1:0] m_data;
   int           m_id;
   int           m_ptr;
   logic         m_err;
   logic [N-1:0] rdy_seen;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Gate reference: {err, data}
   function automatic logic [W:0] gate_ref(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
      case (op)
         3'd0: return {1'b0, a & b};
         3'd1: return {1'b0, a | b};
         3'd2: return {1'b0, ~a};
         3'd3: return {1'b0, ~(a & b)};
         3'd4: return {1'b0, ~(a | b)};
         3'd5: return {1'b0, a ^ b};
         3'd6: return {1'b0, ~(a ^ b)};
`ifdef LOGIC_ARB_ERR_EN
         default: return {1'b1, {W{1'b0}}};
`else
         default: return {1'b0, a};
`endif
      endcase
   endfunction

   // First valid requester at or after the pointer, or -1.
   function automatic int pick();
      for (int d = 0; d < N; d++) begin
         if (req_valid[(m_ptr + d) % N]) return (m_ptr + d) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] exp_ready();
      logic [N-1:0] r;
      int w;
      r = '0;
      w = pick();
      if (rst_n && w >= 0 && (!m_valid || rsp_ready)) r[w] = 1'b1;
      return r;
   endfunction

   // Compare DUT against the model on the falling edge.
   task automatic half_check();
      @(negedge clk);
      rdy_seen = req_ready;
      chk("req_ready", req_ready, exp_ready());
      chk("rsp_valid", rsp_valid, m_valid);
      chk("rsp_data",  rsp_data,  m_data);
      chk("rsp_id",    rsp_id,    m_id);
`ifdef LOGIC_ARB_ERR_EN
      chk("rsp_err",   rsp_err,   m_err);
`endif
      if (sb_on && rsp_valid && rsp_ready) begin
         chk("sb_avail", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) chk("sweep_data", rsp_data, exp_q.pop_front());
      end
   endtask

   task automatic edge_update();
      logic [W:0] r;
      int w;
      @(posedge clk);
      if (!rst_n) begin
         m_valid = 1'b0; m_data = '0; m_id = 0; m_ptr = 0; m_err = 1'b0;
      end else begin
         w = pick();
         if (w >= 0 && (!m_valid || rsp_ready)) begin
            r = gate_ref(req_op[3*w +: 3], req_a[W*w +: W], req_b[W*w +: W]);
            m_data  = r[W-1:0];
            m_err   = r[W];
            m_id    = w;
            m_valid = 1'b1;
            m_ptr   = (w + 1) % N;
         end else if (m_valid && rsp_ready) begin
            m_valid = 1'b0;
         end
      end
      #1;
   endtask

   task automatic step();
      half_check();
      edge_update();
   endtask

   // driver tasks
   task automatic set_req(input int i, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b);
      req_valid[i]     = 1'b1;
      req_op[3*i +: 3] = op;
      req_a[W*i +: W]  = a;
      req_b[W*i +: W]  = b;
   endtask

   task automatic clr_all();
      req_valid = '0;
   endtask

   logic [W-1:0] sweep_tbl [6] = '{8'hAF, 8'h5A, 8'hFA, 8'h50, 8'hAA, 8'h55};
   int           rr_seq    [6] = '{0, 1, 2, 3, 0, 1};

   initial begin
      rst_n = 1'b0; rsp_ready = 1'b0;
      req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
      @(posedge clk); #1;
      m_valid = 1'b0; m_data = '0; m_id = 0; m_ptr = 0; m_err = 1'b0;

      // reset: two cycles, requests present must not be granted
      for (int i = 0; i < N; i++) set_req(i, 3'd0, 8'hFF, 8'hFF);
      #1;
      chk("rst_ready", req_ready, 0);
      step(); step();
      chk("rst_valid", rsp_valid, 0);
      chk("rst_data",  rsp_data,  0);
      chk("rst_id",    rsp_id,    0);

      // single AND
      rst_n = 1'b1; clr_all(); rsp_ready = 1'b1;
      set_req(0, 3'd0, 8'hF0, 8'h3C);
      #1;
      chk("and_ready", req_ready, 4'b0001);
      step();
      chk("and_valid", rsp_valid, 1);
      chk("and_data",  rsp_data,  8'h30);
      chk("and_id",    rsp_id,    0);
      clr_all(); step();

      // opcode sweep on requester 1, one result per cycle
      sb_on = 1'b1;
      for (int k = 0; k < 6; k++) begin
         set_req(1, 3'(k + 1), 8'hA5, 8'h0F);
         exp_q.push_back(sweep_tbl[k]);
         step();
         chk("sweep_valid", rsp_valid, 1);
      end
      clr_all(); step();
      sb_on = 1'b0;
      chk("sweep_drained", exp_q.size(), 0);

      // round robin from a fresh pointer
      rst_n = 1'b0; step(); rst_n = 1'b1;
      for (int i = 0; i < N; i++) set_req(i, 3'd5, 8'(8'h11 * (i + 1)), 8'h0F);
      for (int k = 0; k < 6; k++) begin
         #1;
         chk("rr_onehot", $countones(req_ready), 1);
         step();
         chk("rr_id", rsp_id, rr_seq[k]);
      end
      clr_all(); step();

      // backpressure
      set_req(2, 3'd5, 8'h12, 8'h34);
      step();
      chk("bp_data", rsp_data, 8'h26);
      chk("bp_id",   rsp_id,   2);
      set_req(2, 3'd0, 8'hFF, 8'h0F);
      rsp_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("bp_ready", req_ready, 0);
         step();
         chk("bp_hold",  rsp_data,  8'h26);
         chk("bp_valid", rsp_valid, 1);
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_release", req_ready, 4'b0100);
      step();
      chk("bp_next_data", rsp_data, 8'h0F);
      chk("bp_next_id",   rsp_id,   2);

      // reset while a result is held
      rsp_ready = 1'b0;
      for (int i = 0; i < N; i++) set_req(i, 3'd1, 8'h01, 8'h02);
      rst_n = 1'b0;
      step();
      chk("mid_rst_valid", rsp_valid, 0);
      rst_n = 1'b1; rsp_ready = 1'b1;
      #1;
      chk("mid_rst_grant", req_ready, 4'b0001);
      step();
      chk("mid_rst_id", rsp_id, 0);

      // opcode 7, then a legal op on the same requester
      clr_all();
      set_req(3, 3'd7, 8'h5A, 8'h33);
      step();
`ifdef LOGIC_ARB_ERR_EN
      chk("op7_data", rsp_data, 8'h00);
      chk("op7_err",  rsp_err,  1);
`else
      chk("op7_data", rsp_data, 8'h5A);
`endif
      set_req(3, 3'd2, 8'h5A, 8'h00);
      step();
      chk("not_data", rsp_data, 8'hA5);
`ifdef LOGIC_ARB_ERR_EN
      chk("not_err",  rsp_err,  0);
`endif
      clr_all(); step();

      // withdraw while blocked: no result is produced
      rsp_ready = 1'b0;
      set_req(0, 3'd0, 8'h0F, 8'hFF);
      step();
      set_req(1, 3'd1, 8'hC3, 8'h3C);
      req_valid[0] = 1'b0;
      step(); step();
      req_valid[1] = 1'b0; rsp_ready = 1'b1;
      step();
      chk("wd_valid", rsp_valid, 0);
      chk("wd_id",    rsp_id,    0);
      chk("wd_data",  rsp_data,  8'h0F);

      // random traffic, payload held until accepted or withdrawn
      for (int c = 0; c < 400; c++) begin
         rsp_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && rdy_seen[i]) begin
               req_valid[i] = 1'b0;
            end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
               req_valid[i] = 1'b0;
            end
            if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
               set_req(i, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                       8'($urandom_range(0, 255)));
            end
         end
         if ($urandom_range(0, 99) == 0) rst_n = 1'b0; else rst_n = 1'b1;
         step();
      end

      rst_n = 1'b1; clr_all(); rsp_ready = 1'b1;
      step(); step();
      chk("end_idle", rsp_valid, 0);
      chk("sb_left", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Hard time limit in case the bench stalls.
   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish by 200000");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/logic_op_arbiter.md
Name: logic_op_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one bitwise logic unit among N_REQ requesters.
- The unit supports AND, OR, NOT, NAND, NOR, XOR and XNOR.
- Each requester presents an opcode and two operands through a valid/ready handshake.
- The block grants one requester per cycle, computes the selected gate function over WIDTH bits and holds a registered, tagged result until the consumer accepts it.
- It sits between several client engines and the shared gate datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand and result width in bits.
- ID_W, 2, width of rsp_id; must equal clog2(N_REQ).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req_valid  input  N_REQ  per-requester request valid.
- req_ready  output  N_REQ  per-requester accept; at most one bit high (one-hot or zero).
- req_op  input  3*N_REQ  opcode; requester i uses bits [3i+2:3i].
- req_a  input  WIDTH*N_REQ  operand A; requester i uses slice i.
- req_b  input  WIDTH*N_REQ  operand B; requester i uses slice i.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts the result.
- rsp_data  output  WIDTH  result.
- rsp_id  output  ID_W  index of the requester that owns rsp_data.

Behaviour:
- Reset: on a clk edge with rst_n=0:
  - rsp_valid=0, rsp_data=0, rsp_id=0.
  - State=IDLE, round-robin pointer rr_ptr=0.
  - req_ready is 0 for the duration of reset.
- Opcodes:
  - 0 AND, 1 OR, 2 NOT (~a, b ignored), 3 NAND, 4 NOR, 5 XOR, 6 XNOR.
  - All are bitwise over WIDTH bits.
  - Opcode 7: see Optional Feature.
- States:
  - IDLE: no result held.
  - RESP: result held with rsp_valid=1.
- can_accept = (state==IDLE) | (state==RESP & rsp_ready).
- Arbitration (combinational):
  - Winner = first i with req_valid[i]=1, searching from rr_ptr upward with wrap-around modulo N_REQ.
  - req_ready[winner] = can_accept; all other req_ready bits = 0.
  - If no req_valid bit is set, req_ready = 0.
- Accept occurs when req_valid[w] & req_ready[w]. On that edge:
  - rsp_data <= f(op, a, b) of the winner.
  - rsp_id <= w.
  - rsp_valid <= 1; state -> RESP.
  - rr_ptr <= (w+1) mod N_REQ.
- Latency and throughput:
  - Result is visible one cycle after the accept edge.
  - Back-to-back: in RESP with rsp_ready=1 and a request pending, the old result retires and the new one loads on the same edge. rsp_valid stays 1, giving 1 op/cycle sustained.
- RESP with rsp_ready=1 and no request: rsp_valid <= 0, state -> IDLE. rsp_data keeps its last value.
- RESP with rsp_ready=0:
  - rsp_valid, rsp_data and rsp_id are held stable; req_ready = 0.
  - rr_ptr is unchanged, so the pending requester wins once rsp_ready is seen.
- Requesters must hold req_op, req_a and req_b stable while req_valid=1 and not yet accepted. Dropping req_valid before acceptance is allowed: the request is withdrawn and no result is produced.
- Fairness: a requester with valid held high is granted within N_REQ accepts.
- Reset mid-operation: a held result is discarded (rsp_valid=0 on the next edge), no acceptance occurs in that cycle, and rr_ptr returns to 0.
- No combinational path from rsp_data to req inputs. req_ready depends combinationally on req_valid, state and rsp_ready only.

Optional Feature:
- Macro LOGIC_ARB_ERR_EN.
- Defined:
  - Extra output port rsp_err (1 bit), registered alongside rsp_data and reset to 0.
  - Opcode 7 is accepted normally but yields rsp_data=0 and rsp_err=1.
  - Legal opcodes give rsp_err=0.
- Not defined:
  - No rsp_err port.
  - Opcode 7 acts as BUF: rsp_data = a.
- All other behaviour is identical in both builds.

Test Plan:
- Reset then single op: after rst_n=0 for 2 cycles then rst_n=1, req0 sends op=0 (AND), a=8'hF0, b=8'h3C -> req_ready[0]=1 that cycle; next cycle rsp_valid=1, rsp_data=8'h30, rsp_id=0.
- Opcode sweep: req1 with a=8'hA5, b=8'h0F, opcodes 1..6 -> rsp_data = 8'hAF, 8'h5A, 8'hFA, 8'h50, 8'hAA, 8'h55 in order, rsp_ready tied 1, one result per cycle.
- Round-robin: all four requesters valid continuously with rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1, and exactly one req_ready bit high each cycle.
- Backpressure: rsp_ready=0 for 5 cycles after a result (op=5, a=8'h12, b=8'h34) -> rsp_data=8'h26 held and req_ready=0 throughout; the pending req2 is accepted on the cycle rsp_ready returns to 1.
- Reset mid-operation: rsp_valid=1 with rsp_ready=0 and rst_n pulsed low one cycle -> next cycle rsp_valid=0; with all requesters valid afterwards, the first grant goes to req0.
- Opcode 7 with a=8'h5A: with LOGIC_ARB_ERR_EN -> rsp_data=8'h00, rsp_err=1; without it -> rsp_data=8'h5A.
